// File: rtl/exp_diff_serial_ctrl.sv
// exp_diff_serial_ctrl: bit-serial |ExpA - ExpB| controller for FP add alignment.
// One shared FullSubtractor cell is stepped LSB-first over WIDTH cycles for
// ExpA - ExpB; on a final borrow a second pass computes 0 - R to negate.
// Optional macro: EXP_DIFF_SAT_EN clamps Diff to SAT_LIMIT.

module FullSubtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);
    // One-bit difference and borrow-out of A - B - Bin
    always_comb begin
        D    = A ^ B ^ Bin;
        Bout = (~A & B) | (~(A ^ B) & Bin);
    end
endmodule

module exp_diff_serial_ctrl #(
    parameter int WIDTH     = 8,
    parameter int SAT_LIMIT = 25
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start_Valid,
    output logic             Start_Ready,
    input  logic [WIDTH-1:0] ExpA,
    input  logic [WIDTH-1:0] ExpB,
    output logic             Done_Valid,
    input  logic             Done_Ready,
    output logic [WIDTH-1:0] Diff,
    output logic             ASmaller,
    output logic             Zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUB,
        S_NEG,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_r_sh;
    logic             r_bflop;
    logic             r_neg;
    logic [CW-1:0]    r_cnt;

    logic             w_cell_a;
    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic [WIDTH-1:0] w_r_next;
    logic [WIDTH-1:0] w_diff_out;

    // NEG pass forces the minuend to zero so the cell computes 0 - R
    always_comb begin
        w_cell_a = (r_state == S_SUB) ? r_a_sh[0] : 1'b0;
        w_r_next = {w_d, r_r_sh[WIDTH-1:1]};
        w_last   = (r_cnt == CW'(WIDTH - 1));
    end

    FullSubtractor u_fs (
        .A    (w_cell_a),
        .B    (r_b_sh[0]),
        .Bin  (r_bflop),
        .D    (w_d),
        .Bout (w_bout)
    );

`ifdef EXP_DIFF_SAT_EN
    localparam logic [WIDTH-1:0] SAT_W = WIDTH'(SAT_LIMIT);

    // Clamp the shift amount; flags still use the unclamped result
    always_comb begin
        w_diff_out = (w_r_next > SAT_W) ? SAT_W : w_r_next;
    end
`else
    // Unclamped shift amount
    always_comb begin
        w_diff_out = w_r_next;
    end
`endif

    // Operands are only accepted while idle
    always_comb begin
        Start_Ready = (r_state == S_IDLE);
    end

    // Controller FSM, serial datapath and registered result outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state    <= S_IDLE;
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_r_sh     <= '0;
            r_bflop    <= 1'b0;
            r_neg      <= 1'b0;
            r_cnt      <= '0;
            Done_Valid <= 1'b0;
            Diff       <= '0;
            ASmaller   <= 1'b0;
            Zero       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start_Valid) begin
                        r_a_sh  <= ExpA;
                        r_b_sh  <= ExpB;
                        r_bflop <= 1'b0;
                        r_neg   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_SUB;
                    end
                end
                S_SUB, S_NEG: begin
                    r_r_sh  <= w_r_next;
                    r_bflop <= w_bout;
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cnt <= '0;
                        if ((r_state == S_SUB) && w_bout) begin
                            // Negative difference: reload R as the subtrahend of 0 - R
                            r_b_sh  <= w_r_next;
                            r_a_sh  <= '0;
                            r_bflop <= 1'b0;
                            r_neg   <= 1'b1;
                            r_state <= S_NEG;
                        end else begin
                            Diff       <= w_diff_out;
                            ASmaller   <= r_neg;
                            Zero       <= (w_r_next == '0);
                            Done_Valid <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (Done_Ready) begin
                        Done_Valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_exp_diff_serial_ctrl.sv
// Scoreboard bench for exp_diff_serial_ctrl: driver pushes expected results
// from an arithmetic reference, monitor checks whenever Done_Valid is high.

module tb_exp_diff_serial_ctrl;
    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Start_Valid = 1'b0;
    logic       Start_Ready;
    logic [7:0] ExpA = '0;
    logic [7:0] ExpB = '0;
    logic       Done_Valid;
    logic       Done_Ready = 1'b1;
    logic [7:0] Diff;
    logic       ASmaller;
    logic       Zero;

    exp_diff_serial_ctrl #(.WIDTH(8), .SAT_LIMIT(25)) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Start_Valid (Start_Valid),
        .Start_Ready (Start_Ready),
        .ExpA        (ExpA),
        .ExpB        (ExpB),
        .Done_Valid  (Done_Valid),
        .Done_Ready  (Done_Ready),
        .Diff        (Diff),
        .ASmaller    (ASmaller),
        .Zero        (Zero)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int diff;
        int asm;
        int zero;
        int lat;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_mis = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the two exponents
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   d;
        d = (a >= b) ? a - b : b - a;
`ifdef EXP_DIFF_SAT_EN
        e.diff = (d > 25) ? 25 : d;
`else
        e.diff = d;
`endif
        e.asm  = (a < b) ? 1 : 0;
        e.zero = (d == 0) ? 1 : 0;
        e.lat  = (a < b) ? 16 : 8;
        e.acc  = 0;
        return e;
    endfunction

    // Monitor: compares against queue head whenever a result is presented
    initial begin
        exp_t e;
        bit   first = 1'b1;
        bit   prev_hs = 1'b0;
        forever begin
            @(negedge Clk);
            #2;
            if (!Rst_n) begin
                chk("rst_done_valid", Done_Valid, 0);
                chk("rst_diff", Diff, 0);
                chk("rst_asmaller", ASmaller, 0);
                chk("rst_zero", Zero, 0);
                chk("rst_start_ready", Start_Ready, 1);
                first = 1'b1;
                prev_hs = 1'b0;
            end else begin
                if (prev_hs) begin
                    chk("ready_after_handshake", Start_Ready, 1);
                    chk("valid_drop_after_handshake", Done_Valid, 0);
                end
                prev_hs = 1'b0;
                if (Done_Valid) begin
                    if (sb.size() == 0) begin
                        chk("spurious_done_valid", Done_Valid, 0);
                    end else begin
                        e = sb[0];
                        if (first) chk("latency", cyc - e.acc, e.lat);
                        first = 1'b0;
                        chk("diff", Diff, e.diff);
                        chk("asmaller", ASmaller, e.asm);
                        chk("zero", Zero, e.zero);
                        chk("start_ready_busy", Start_Ready, 0);
                        if (Done_Ready) begin
                            void'(sb.pop_front());
                            first = 1'b1;
                            prev_hs = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit rdy);
        exp_t e;
        bit   ok = 1'b0;
        @(negedge Clk);
        ExpA = a;
        ExpB = b;
        Start_Valid = 1'b1;
        Done_Ready = rdy;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (Start_Ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
        end else begin
            e = model(int'(a), int'(b));
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge Clk);
        Start_Valid = 1'b0;
        ExpA = 8'($urandom);
        ExpB = 8'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(negedge Clk);
        end
        chk("drain_timeout", sb.size(), 0);
        Done_Ready = 1'b1;
    endtask

    // Hold Done_Ready low for bp cycles while poking Start_Valid, then release
    task automatic op(input logic [7:0] a, input logic [7:0] b, input int bp);
        bit seen = 1'b0;
        issue(a, b, bp == 0);
        if (bp > 0) begin
            for (int i = 0; i < 50; i++) begin
                #1;
                if (Done_Valid) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge Clk);
            end
            if (!seen) chk("done_wait_timeout", 0, 1);
            for (int k = 0; k < bp; k++) begin
                Start_Valid = 1'b1;
                ExpA = 8'($urandom);
                ExpB = 8'($urandom);
                @(negedge Clk);
                #1;
            end
            Start_Valid = 1'b0;
            Done_Ready = 1'b1;
        end
        wait_idle();
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;

        op(8'h85, 8'h80, 0);
        op(8'h80, 8'h85, 0);
        op(8'h7F, 8'h7F, 0);
        op(8'hFF, 8'h00, 0);
        op(8'h00, 8'hFF, 0);
        op(8'h01, 8'h00, 0);
        op(8'h00, 8'h01, 0);
        op(8'h80, 8'h67, 0);
        op(8'h67, 8'h80, 0);
        op(8'h80, 8'h66, 0);
        op(8'h30, 8'h91, 5);
        op(8'h91, 8'h30, 5);

        // Reset 3 cycles into an operation: no result may appear
        issue(8'h20, 8'h90, 1'b1);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b0;
        sb.delete();
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (20) @(negedge Clk);
        op(8'h10, 8'h0C, 0);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom);
            b = (($urandom % 6) == 0) ? a : 8'($urandom);
            op(a, b, int'($urandom_range(0, 3)));
        end

        repeat (4) @(negedge Clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/exp_diff_serial_ctrl.md
Name: exp_diff_serial_ctrl

Overview:
Bit-serial exponent-difference controller for the 32-bit floating-point adder's alignment stage. It sequences a single 1-bit FullSubtractor cell over WIDTH cycles to form ExpA - ExpB. If a borrow results, it makes a second serial pass through the same cell to negate the result. It returns |ExpA - ExpB| as the mantissa shift amount, plus a swap flag, through valid/ready handshakes on both sides.

Parameters:
WIDTH, 8, exponent width in bits; also the bit-counter range.
SAT_LIMIT, 25, shift-amount clamp value; used only when EXP_DIFF_SAT_EN is defined.

Ports:
Clk  input  1  rising-edge clock
Rst_n  input  1  asynchronous, active-low reset
Start_Valid  input  1  operands ExpA/ExpB are valid
Start_Ready  output  1  controller can accept operands
ExpA  input  WIDTH  exponent of operand A
ExpB  input  WIDTH  exponent of operand B
Done_Valid  output  1  result outputs are valid
Done_Ready  input  1  consumer accepts the result
Diff  output  WIDTH  |ExpA - ExpB| (clamped if EXP_DIFF_SAT_EN)
ASmaller  output  1  1 when ExpA < ExpB (swap operands downstream)
Zero  output  1  1 when ExpA == ExpB

Behaviour:
- One clock domain. Reset is asynchronous and active-low; it is asserted on Rst_n low and released synchronously to Clk.
- Reset state:
  - state = IDLE.
  - Start_Ready = 1 (combinational from IDLE).
  - Done_Valid = 0; Diff = 0; ASmaller = 0; Zero = 0.
  - Internal shift registers, bit counter and borrow flop cleared.
- Datapath:
  - Exactly one FullSubtractor instance, shared by both passes.
  - A_sh and B_sh are right-shifting operand registers; R_sh is a right-shifting result register filled MSB-first from its top.
  - Bflop holds the borrow; Cnt runs 0..WIDTH-1.
- IDLE:
  - Start_Ready = 1.
  - On an edge with Start_Valid & Start_Ready: A_sh <= ExpA, B_sh <= ExpB, Bflop <= 0, Cnt <= 0, state <= SUB.
- SUB:
  - Cell inputs: A = A_sh[0], B = B_sh[0], Bin = Bflop.
  - Each edge: R_sh <= {D, R_sh[WIDTH-1:1]}, Bflop <= Bout, A_sh and B_sh shift right, Cnt++.
  - On the edge where Cnt == WIDTH-1:
    - If Bout = 1: B_sh <= the completed R_sh value (including this edge's D), A_sh <= 0, Bflop <= 0, Cnt <= 0, neg_flag <= 1, state <= NEG.
    - Else: state <= DONE.
- NEG:
  - Same cell with A = 0 and B = B_sh[0], so the pass computes 0 - R (two's complement).
  - Same shift and count rules as SUB.
  - After WIDTH edges, state <= DONE. The final borrow is ignored.
- Entering DONE:
  - Diff <= result; ASmaller <= neg_flag; Zero <= (result == 0); Done_Valid <= 1.
- DONE:
  - Start_Ready = 0; outputs held stable.
  - On Done_Valid & Done_Ready: Done_Valid <= 0, state <= IDLE.
  - Diff, ASmaller and Zero keep their value until the next result is written.
- Latency, counted from the accept edge to the first cycle Done_Valid = 1:
  - WIDTH cycles when ExpA >= ExpB.
  - 2*WIDTH cycles when ExpA < ExpB.
- Throughput: at most one operation per (latency + 1) cycles. A new start is accepted no earlier than the cycle after the Done handshake.
- Start_Valid while busy (SUB/NEG/DONE) is ignored. ExpA/ExpB may change freely after the accept edge.
- Done_Ready held high in advance: the handshake completes in the first DONE cycle.
- Reset mid-operation (any state): immediate return to the reset state. The partial result is discarded and no Done_Valid pulse is produced.
- Illegal state encodings recover to IDLE.

Optional Feature:
EXP_DIFF_SAT_EN
- Defined: on entering DONE, Diff <= (result > SAT_LIMIT) ? SAT_LIMIT : result. Zero and ASmaller are computed from the unclamped result. Latency is unchanged.
- Undefined: Diff is the full unclamped |ExpA - ExpB|, and SAT_LIMIT is unused.

Test Plan:
1. ExpA=8'h85, ExpB=8'h80 -> Done_Valid 8 cycles after accept; Diff=5, ASmaller=0, Zero=0.
2. ExpA=8'h80, ExpB=8'h85 -> Done_Valid 16 cycles after accept; Diff=5, ASmaller=1, Zero=0.
3. ExpA=ExpB=8'h7F -> latency 8; Diff=0, Zero=1, ASmaller=0.
4. ExpA=8'hFF, ExpB=8'h00 -> Diff=255 without macro; Diff=25 with EXP_DIFF_SAT_EN; ExpA=8'h00, ExpB=8'hFF -> Diff=255/25, ASmaller=1.
5. Backpressure: Done_Ready low for 5 cycles in DONE -> outputs stable and Done_Valid held high; Start_Valid pulses ignored; after the handshake, Start_Ready=1 on the next cycle.
6. Rst_n pulsed low 3 cycles after accept -> all outputs 0 and Start_Ready=1 while Rst_n low; no Done_Valid; next operation (8'h10 - 8'h0C) gives Diff=4 at the normal latency.
